// File: rtl/lock_pkg.sv
// Shared types and constants for the lock-picking pin-tumbler model.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lock_pkg;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PICKING,
        ST_UNLOCKED
    } game_state_t;

    localparam int          LIFT_W     = 6;
    localparam int          TARGET_MIN = 8;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;

    typedef logic [LIFT_W-1:0] lift_t;
endpackage

// File: rtl/lock_pins_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded on reset.
// Latency: one step per clock edge; exposes the low byte of the current state.
// Backpressure: none, steps unconditionally.
module lfsr16
    import lock_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] rnd
);
    logic [15:0] state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LFSR_SEED;
        end else begin
            state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
        end
    end

    assign rnd = state[7:0];
endmodule

// File: rtl/lock_pins.sv
// Pin-tumbler lock model: per-pin lift, binding order, hold-to-set and unlock detection.
// Latency: one frame from pick/tension sample to registered outputs.
// Backpressure: none; consumes one pick sample per frame_clk edge.
module lock_pins
    import lock_pkg::*;
#(
    parameter int NUM_PINS    = 5,
    parameter int PIN_X0      = 200,
    parameter int PIN_PITCH   = 40,
    parameter int PIN_W       = 16,
    parameter int PIN_BASE_Y  = 240,
    parameter int TOL         = 2,
    parameter int HOLD_FRAMES = 8
) (
    input  logic                       frame_clk,
    input  logic                       Reset_n,
    input  logic [9:0]                 pickX,
    input  logic [9:0]                 pickY,
    input  logic                       tension,
    input  logic                       new_game,
    output logic [NUM_PINS*LIFT_W-1:0] pin_lift,
    output logic [NUM_PINS-1:0]        pin_set,
    output logic [2:0]                 binding_idx,
    output logic                       unlocked,
    output logic                       busy_load
);
    localparam int HCW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    game_state_t          state_q, state_d;
    logic [2:0]           load_k_q, load_k_d;
    logic [2:0]           bind_start_q, bind_start_d;
    logic [HCW-1:0]       hold_q, hold_d;
    lift_t                target_q [NUM_PINS];
    lift_t                target_d [NUM_PINS];
    lift_t                lift_q   [NUM_PINS];
    lift_t                lift_d   [NUM_PINS];
    logic [NUM_PINS-1:0]  set_d;
    logic [2:0]           bind_d, next_bind;
    logic                 unlocked_d, busy_d;

    logic [7:0]           rnd;
    logic [9:0]           lift_diff;
    lift_t                raw, cur_tgt;
    logic                 hit, aim, overset, in_window;
    logic [2:0]           col;

    lfsr16 u_lfsr (
        .clk   (frame_clk),
        .rst_n (Reset_n),
        .rnd   (rnd)
    );

    // Raw lift saturates so the pick's wrap region (small Y) reads as fully lifted.
    assign lift_diff = 10'(PIN_BASE_Y) - pickY;
    always_comb begin
        raw = '0;
        if (pickY < 10'(PIN_BASE_Y)) begin
            raw = (lift_diff > 10'((1 << LIFT_W) - 1)) ? '1 : lift_diff[LIFT_W-1:0];
        end
    end

    always_comb begin
        hit = 1'b0;
        col = '0;
        for (int i = 0; i < NUM_PINS; i++) begin
            if (({2'b00, pickX} >= 12'(PIN_X0 + i * PIN_PITCH)) &&
                ({2'b00, pickX} <  12'(PIN_X0 + i * PIN_PITCH + PIN_W))) begin
                hit = 1'b1;
                col = 3'(i);
            end
        end
    end

    assign aim       = hit && (col == binding_idx);
    assign cur_tgt   = target_q[binding_idx];
    assign overset   = aim && ({1'b0, raw} > {1'b0, cur_tgt} + 7'(TOL));
    assign in_window = aim && ({1'b0, raw} + 7'(TOL) >= {1'b0, cur_tgt});
    assign next_bind = (binding_idx == 3'(NUM_PINS - 1)) ? 3'd0 : binding_idx + 3'd1;

    always_comb begin
        state_d      = state_q;
        load_k_d     = load_k_q;
        bind_start_d = bind_start_q;
        hold_d       = hold_q;
        target_d     = target_q;
        set_d        = pin_set;
        bind_d       = binding_idx;
        unlocked_d   = unlocked;

        if (new_game) begin
            state_d    = ST_LOAD;
            load_k_d   = '0;
            unlocked_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_LOAD: begin
                    target_d[load_k_q] = lift_t'(TARGET_MIN) + {1'b0, rnd[4:0]};
                    if (load_k_q == 3'(NUM_PINS - 1)) begin
                        bind_start_d = 3'({24'd0, rnd} % NUM_PINS);
                        set_d        = '0;
                        hold_d       = '0;
                        bind_d       = bind_start_d;
                        state_d      = ST_PICKING;
                    end else begin
                        load_k_d = load_k_q + 3'd1;
                    end
                end
                ST_PICKING: begin
                    // Tension loss and overset both drop every set pin back to the start.
                    if (!tension || overset) begin
                        set_d  = '0;
                        hold_d = '0;
                        bind_d = bind_start_q;
                    end else if (in_window) begin
                        if (hold_q == HCW'(HOLD_FRAMES - 1)) begin
                            set_d[binding_idx] = 1'b1;
                            hold_d             = '0;
                            bind_d             = next_bind;
                            if (&set_d) begin
                                state_d    = ST_UNLOCKED;
                                unlocked_d = 1'b1;
                            end
                        end else begin
                            hold_d = hold_q + HCW'(1);
                        end
                    end else begin
                        hold_d = '0;
                    end
                end
                default: ;
            endcase
        end

        busy_d = (state_d == ST_LOAD);
        for (int i = 0; i < NUM_PINS; i++) begin
            lift_d[i] = set_d[i] ? target_d[i] : ((hit && col == 3'(i)) ? raw : '0);
        end
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= ST_IDLE;
            load_k_q     <= '0;
            bind_start_q <= '0;
            hold_q       <= '0;
            pin_set      <= '0;
            binding_idx  <= '0;
            unlocked     <= 1'b0;
            busy_load    <= 1'b0;
            for (int i = 0; i < NUM_PINS; i++) begin
                target_q[i] <= '0;
                lift_q[i]   <= '0;
            end
        end else begin
            state_q      <= state_d;
            load_k_q     <= load_k_d;
            bind_start_q <= bind_start_d;
            hold_q       <= hold_d;
            pin_set      <= set_d;
            binding_idx  <= bind_d;
            unlocked     <= unlocked_d;
            busy_load    <= busy_d;
            target_q     <= target_d;
            lift_q       <= lift_d;
        end
    end

    always_comb begin
        pin_lift = '0;
        for (int i = 0; i < NUM_PINS; i++) begin
            pin_lift[i*LIFT_W +: LIFT_W] = lift_q[i];
        end
    end
endmodule

// File: tb/tb_lock_pins.sv
// Self-checking bench for lock_pins against a frame-level behavioural model.
// Latency: n/a.  Backpressure: n/a.
module tb_lock_pins;
    localparam int NP = 5, X0 = 200, PITCH = 40, W = 16, BASE = 240, TOL = 2, HOLD = 8;
    localparam int OW = NP * 6 + NP + 5;

    logic            frame_clk = 1'b0;
    logic            Reset_n, tension, new_game;
    logic [9:0]      pickX, pickY;
    logic [NP*6-1:0] pin_lift;
    logic [NP-1:0]   pin_set;
    logic [2:0]      binding_idx;
    logic            unlocked, busy_load;
    logic [OW-1:0]   outs;

    int checks = 0, passed = 0;

    // Model: 0 idle, 1 load, 2 picking, 3 unlocked
    int          m_mode, m_k, m_bind, m_bstart, m_hold;
    int          m_tgt [NP];
    int          m_lift[NP];
    bit          m_set [NP];
    bit          m_unl;
    logic [15:0] m_lfsr;

    lock_pins dut (
        .frame_clk   (frame_clk),
        .Reset_n     (Reset_n),
        .pickX       (pickX),
        .pickY       (pickY),
        .tension     (tension),
        .new_game    (new_game),
        .pin_lift    (pin_lift),
        .pin_set     (pin_set),
        .binding_idx (binding_idx),
        .unlocked    (unlocked),
        .busy_load   (busy_load)
    );

    always #5 frame_clk = ~frame_clk;
    assign outs = {pin_lift, pin_set, binding_idx, unlocked, busy_load};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_mode = 0; m_k = 0; m_bind = 0; m_bstart = 0; m_hold = 0; m_unl = 0;
        m_lfsr = 16'hACE1;
        for (int i = 0; i < NP; i++) begin
            m_tgt[i] = 0; m_lift[i] = 0; m_set[i] = 0;
        end
    endtask

    task automatic model_step();
        int py, px, raw, col, off, t;
        bit all_set;
        py  = int'(pickY);
        px  = int'(pickX);
        raw = 0;
        if (py < BASE) raw = (BASE - py > 63) ? 63 : BASE - py;
        col = -1;
        if (px >= X0) begin
            off = px - X0;
            if (off / PITCH < NP && off % PITCH < W) col = off / PITCH;
        end
        if (new_game) begin
            m_mode = 1; m_k = 0; m_unl = 0;
        end else if (m_mode == 1) begin
            m_tgt[m_k] = 8 + int'(m_lfsr[4:0]);
            if (m_k == NP - 1) begin
                m_bstart = int'(m_lfsr[7:0]) % NP;
                m_bind   = m_bstart;
                m_hold   = 0;
                for (int i = 0; i < NP; i++) m_set[i] = 0;
                m_mode = 2;
            end else begin
                m_k++;
            end
        end else if (m_mode == 2) begin
            t = m_tgt[m_bind];
            if (!tension || (col == m_bind && raw > t + TOL)) begin
                for (int i = 0; i < NP; i++) m_set[i] = 0;
                m_hold = 0;
                m_bind = m_bstart;
            end else if (col == m_bind && raw >= t - TOL) begin
                m_hold++;
                if (m_hold == HOLD) begin
                    m_hold = 0;
                    m_set[m_bind] = 1;
                    m_bind = (m_bind + 1) % NP;
                    all_set = 1;
                    for (int i = 0; i < NP; i++) if (!m_set[i]) all_set = 0;
                    if (all_set) begin
                        m_mode = 3; m_unl = 1;
                    end
                end
            end else begin
                m_hold = 0;
            end
        end
        for (int i = 0; i < NP; i++) m_lift[i] = m_set[i] ? m_tgt[i] : ((col == i) ? raw : 0);
        m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    endtask

    function automatic logic [OW-1:0] exp_outs();
        logic [NP*6-1:0] l;
        logic [NP-1:0]   s;
        for (int i = 0; i < NP; i++) begin
            l[i*6 +: 6] = 6'(m_lift[i]);
            s[i]        = m_set[i];
        end
        return {l, s, 3'(m_bind), m_unl, (m_mode == 1)};
    endfunction

    task automatic tick();
        model_step();
        @(posedge frame_clk);
        #1;
    endtask

    // Place the pick in a random spot inside a pin column at raw lift target+d.
    task automatic aim(input int pin, input int d);
        pickX = 10'(X0 + pin * PITCH + int'($urandom_range(0, W - 1)));
        pickY = 10'(BASE - (m_tgt[pin] + d));
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; tension = 1'b0; new_game = 1'b0; pickX = '0; pickY = '0;
        model_reset();
        repeat (3) @(posedge frame_clk);
        #1;
        checks++;
        if (outs !== '0) $display("FAIL reset_state: got %h required %h", outs, {OW{1'b0}});
        else passed++;
        Reset_n = 1'b1;
        tick();
        checks++;
        if (outs !== exp_outs()) $display("FAIL idle_frame: got %h required %h", outs, exp_outs());
        else passed++;
    endtask

    task automatic test_load();
        int busy_cnt = 0;
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        if (busy_load) busy_cnt++;
        for (int f = 0; f < 6; f++) begin
            tick();
            if (busy_load) busy_cnt++;
            checks++;
            if (outs !== exp_outs()) $display("FAIL load_frame%0d: got %h required %h", f, outs, exp_outs());
            else passed++;
        end
        checks++;
        if (busy_cnt !== 5) $display("FAIL load_busy_frames: got %0d required 5", busy_cnt);
        else passed++;
        checks++;
        if (binding_idx !== 3'(m_bstart)) $display("FAIL load_bind_start: got %0d required %0d", binding_idx, m_bstart);
        else passed++;
    endtask

    task automatic test_set_one();
        int b, nb;
        tension = 1'b1;
        b  = m_bind;
        nb = (b + 1) % NP;
        for (int f = 1; f <= HOLD; f++) begin
            aim(b, int'($urandom_range(0, 2 * TOL)) - TOL);
            tick();
            if (f == HOLD - 1) begin
                checks++;
                if (pin_set[b] !== 1'b0) $display("FAIL set_early: got %b required 0", pin_set[b]);
                else passed++;
            end
        end
        checks++;
        if (pin_set[b] !== 1'b1) $display("FAIL set_on_8th: got %b required 1", pin_set[b]);
        else passed++;
        checks++;
        if (binding_idx !== 3'(nb)) $display("FAIL set_advance: got %0d required %0d", binding_idx, nb);
        else passed++;
        checks++;
        if (outs !== exp_outs()) $display("FAIL set_outs: got %h required %h", outs, exp_outs());
        else passed++;
    endtask

    task automatic test_tension_drop();
        int b;
        b = m_bind;
        repeat (5) begin
            aim(b, 0);
            tick();
        end
        tension = 1'b0;
        tick();
        checks++;
        if (pin_set !== '0) $display("FAIL drop_clear: got %b required 00000", pin_set);
        else passed++;
        checks++;
        if (binding_idx !== 3'(m_bstart)) $display("FAIL drop_bind: got %0d required %0d", binding_idx, m_bstart);
        else passed++;
        tension = 1'b1;
        b = m_bstart;
        for (int f = 1; f <= HOLD; f++) begin
            aim(b, 0);
            tick();
            if (f == HOLD - 1) begin
                checks++;
                if (pin_set !== '0) $display("FAIL drop_hold_cleared: got %b required 00000", pin_set);
                else passed++;
            end
        end
        checks++;
        if (pin_set[b] !== 1'b1) $display("FAIL drop_reset_pin: got %b required 1", pin_set[b]);
        else passed++;
    endtask

    task automatic test_overset();
        aim(m_bind, TOL + 1);
        tick();
        checks++;
        if (pin_set !== '0) $display("FAIL overset_clear: got %b required 00000", pin_set);
        else passed++;
        checks++;
        if (binding_idx !== 3'(m_bstart)) $display("FAIL overset_bind: got %0d required %0d", binding_idx, m_bstart);
        else passed++;
    endtask

    task automatic test_unlock();
        tension = 1'b1;
        for (int p = 0; p < NP; p++) begin
            for (int f = 1; f <= HOLD; f++) begin
                aim(m_bind, int'($urandom_range(0, 2 * TOL)) - TOL);
                tick();
                if (p == NP - 1 && f == HOLD - 1) begin
                    checks++;
                    if (unlocked !== 1'b0) $display("FAIL unlock_early: got %b required 0", unlocked);
                    else passed++;
                end
            end
        end
        checks++;
        if ({unlocked, pin_set} !== {1'b1, {NP{1'b1}}}) $display("FAIL unlock_edge: got %b/%b required 1/11111", unlocked, pin_set);
        else passed++;
        for (int f = 0; f < 10; f++) begin
            tension = 1'($urandom_range(0, 1));
            pickX   = 10'($urandom_range(0, 1023));
            pickY   = 10'($urandom_range(0, 1023));
            tick();
            checks++;
            if (pin_set !== {NP{1'b1}} || unlocked !== 1'b1) $display("FAIL unlock_frozen: got %b/%b required 11111/1", pin_set, unlocked);
            else passed++;
        end
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        checks++;
        if ({busy_load, unlocked} !== 2'b10) $display("FAIL unlock_newgame: got %b required 10", {busy_load, unlocked});
        else passed++;
    endtask

    task automatic test_lift_display();
        tension = 1'b0;
        pickX = '0;
        repeat (5) tick();
        pickX = 10'(X0 + 2 * PITCH + 3);
        pickY = 10'd10;
        tick();
        checks++;
        if (pin_lift[17:12] !== 6'd63) $display("FAIL lift_wrap_sat: got %0d required 63", pin_lift[17:12]);
        else passed++;
        pickX = 10'(X0 + PITCH - 10);
        tick();
        checks++;
        if (pin_lift !== '0) $display("FAIL lift_between: got %h required 0", pin_lift);
        else passed++;
        pickX = 10'(X0 + PITCH + 1);
        pickY = 10'(BASE);
        tick();
        checks++;
        if (pin_lift !== '0) $display("FAIL lift_at_base: got %h required 0", pin_lift);
        else passed++;
        pickY = 10'(BASE - 1);
        tick();
        checks++;
        if (pin_lift[11:6] !== 6'd1) $display("FAIL lift_one: got %0d required 1", pin_lift[11:6]);
        else passed++;
    endtask

    task automatic test_reload_restart();
        int busy_cnt = 0;
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        repeat (2) tick();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        if (busy_load) busy_cnt++;
        for (int f = 0; f < 6; f++) begin
            tick();
            if (busy_load) busy_cnt++;
        end
        checks++;
        if (busy_cnt !== 5) $display("FAIL restart_busy_frames: got %0d required 5", busy_cnt);
        else passed++;
        checks++;
        if (outs !== exp_outs()) $display("FAIL restart_outs: got %h required %h", outs, exp_outs());
        else passed++;
    endtask

    task automatic test_random();
        int r;
        for (int f = 0; f < 400; f++) begin
            new_game = ($urandom_range(0, 99) < 2);
            tension  = ($urandom_range(0, 99) < 95);
            r = int'($urandom_range(0, 99));
            if (r < 80) aim(m_bind, int'($urandom_range(0, 6)) - 3);
            else if (r < 90) aim(int'($urandom_range(0, NP - 1)), int'($urandom_range(0, 6)) - 3);
            else begin
                pickX = 10'($urandom_range(0, 1023));
                pickY = 10'($urandom_range(0, 1023));
            end
            tick();
            checks++;
            if (outs !== exp_outs()) $display("FAIL rand_frame%0d: got %h required %h", f, outs, exp_outs());
            else passed++;
        end
        new_game = 1'b0;
    endtask

    task automatic test_async_reset();
        #2;
        Reset_n = 1'b0;
        #1;
        checks++;
        if (outs !== '0) $display("FAIL async_reset: got %h required %h", outs, {OW{1'b0}});
        else passed++;
        model_reset();
        @(posedge frame_clk);
        #1;
        Reset_n = 1'b1;
        tension = 1'b1;
        pickX = 10'(X0 + 5);
        pickY = 10'(BASE - 20);
        tick();
        checks++;
        if (outs !== exp_outs()) $display("FAIL post_reset_idle: got %h required %h", outs, exp_outs());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_set_one();
        test_tension_drop();
        test_overset();
        test_unlock();
        test_lift_display();
        test_reload_restart();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/lock_pins.md
# lock_pins

Pin-tumbler model for the lock-picking game, directly downstream of the pick motion block. It consumes the pick tip position (`pickX`, `pickY`) once per frame, plus tension and new-game controls. It tracks lift, binding order and set state for each pin, and reports per-pin heights, set flags and an unlocked flag to the renderer and game logic. All state advances on `frame_clk`.

## Interface
- `NUM_PINS`, 5: number of pins (2..8).
- `PIN_X0`, 200: left edge X of pin 0 column.
- `PIN_PITCH`, 40: X spacing between pin columns.
- `PIN_W`, 16: column width in pixels; pin i spans [PIN_X0+i*PIN_PITCH, +PIN_W-1].
- `PIN_BASE_Y`, 240: Y of resting pin bottom; the pick lifts a pin when pickY < PIN_BASE_Y.
- `TOL`, 2: shear-window half-width in lift units.
- `HOLD_FRAMES`, 8: consecutive in-window frames required to set the binding pin.

Ports:
- `frame_clk` in 1: sole clock; one edge per video frame.
- `Reset_n` in 1: asynchronous, active-low reset.
- `pickX` in 10: pick tip X.
- `pickY` in 10: pick tip Y.
- `tension` in 1: tension wrench held (level).
- `new_game` in 1: start a new lock; sampled per frame.
- `pin_lift` out NUM_PINS*6: packed per-pin displayed lift; pin i occupies bits [6i+5:6i].
- `pin_set` out NUM_PINS: pin i is set at the shear line.
- `binding_idx` out 3: index of the current binding pin.
- `unlocked` out 1: all pins set; sticky until the next new_game.
- `busy_load` out 1: high while in LOAD.

## Operation
- FSM states are IDLE, LOAD, PICKING and UNLOCKED. Reset enters IDLE.
- IDLE → LOAD on new_game. new_game in any state → LOAD, and it overrides every other event in that frame.
- LOAD lasts NUM_PINS frames. In frame k it captures target[k] = 8 + lfsr[4:0] (range 8..39).
  - On the final load frame it captures bind_start = lfsr[7:0] mod NUM_PINS, clears pin_set and the hold counter, sets binding_idx = bind_start, then → PICKING.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Seed 16'hACE1 on reset. Steps every frame in every state; it never reaches all-zero.
- Raw lift: raw = PIN_BASE_Y − pickY when pickY < PIN_BASE_Y, saturated to 63; otherwise raw = 0.
- Column hit: col = (pickX − PIN_X0) / PIN_PITCH, valid only when pickX ≥ PIN_X0, col < NUM_PINS and the offset within the pitch is < PIN_W.
  - Implement with a compare chain over the pins, not a divider.
- Displayed pin_lift[i]:
  - target[i] if pin i is set;
  - else raw if i is the hit column;
  - else 0.
- PICKING, evaluated per frame in this priority order:
  1. tension low → clear all pin_set and the hold counter; binding_idx = bind_start.
  2. Hit column == binding_idx and raw > target+TOL → overset: same clear as item 1.
  3. Hit column == binding_idx and |raw − target| ≤ TOL → increment the hold counter.
     - When the counter reaches HOLD_FRAMES−1 in this frame: set pin_set[binding_idx], clear the counter, and advance binding_idx = (binding_idx+1) mod NUM_PINS.
  4. Otherwise → clear the hold counter.
  - Lifting a non-binding pin has no effect on state.
- When the last pin sets, all pin_set bits are 1 → UNLOCKED, and unlocked = 1 on the same edge the final bit sets.
- UNLOCKED: freezes pin_set and ignores tension and the pick. Exits only via new_game.

## Timing
- All outputs are registered and update on posedge frame_clk.
- Latency is one frame from a pickX/pickY/tension sample to its effect on outputs.
- Reset values: pin_lift = 0, pin_set = 0, binding_idx = 0, unlocked = 0, busy_load = 0, targets = 0, LFSR = 16'hACE1.
- Reset asserted mid-game returns to IDLE immediately and asynchronously.
- new_game while in LOAD restarts the load at k = 0.
- Simultaneous tension drop and set-qualifying frame: the drop wins.
- Simultaneous overset and hold: overset wins.
- Hold counter width: clog2(HOLD_FRAMES); it never wraps.
- Wrap-around: pickY in 0..31 (pick-block wrap region) yields raw saturated at 63. pickY ≥ PIN_BASE_Y yields 0.

## Structure
- Package `lock_pkg` holds:
  - `game_state_t` enum;
  - `LIFT_W` = 6, `TARGET_MIN` = 8, `LFSR_SEED`;
  - the `lift_t` typedef.
- Sub-module `lfsr16` (free-running, with seed on reset); instantiated once.

## Test plan
- Reset, then new_game for one frame → busy_load high for 5 frames.
  - Targets match the LFSR sequence from seed ACE1.
  - binding_idx = bind_start, state PICKING.
- With tension = 1, hold pickY = PIN_BASE_Y − target[b] at the binding column for 8 frames → pin_set[b] rises on the 8th edge and binding_idx = b+1.
- Hold the binding pin in window for 5 frames, then drop tension for 1 frame → pin_set all 0, hold count 0, binding_idx = bind_start.
- Lift the binding pin to target+3 → overset clears all previously set pins on the next edge.
- Set all 5 pins in binding order → unlocked = 1 on the edge the 5th pin sets.
  - Later tension toggles leave pin_set = 5'b11111.
  - new_game → LOAD, unlocked = 0.
- pickY = 10 under pin 2 → pin_lift[2] = 63. pickX between columns → all non-set lifts 0.
